// File: rtl/ic7420_pattern_driver.sv
// Exhaustive stimulus/checker for the dual 4-input NAND: sweeps all 256 input
// vectors, compares x/y responses, reports error count and first failing vector.
// Optional: `define IC7420_DRV_STOP_ON_ERR_EN to halt on the first mismatch.
module ic7420_pattern_driver #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] vec_o,
    input  logic       x_i,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic [7:0] first_err_vec
);

    localparam int unsigned VEC_W   = 8;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned DWELL_W = 8;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [VEC_W-1:0]   VEC_LAST   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [VEC_W-1:0]   first_err_q, first_err_d;
    logic               err_seen_q, err_seen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic exp_x_c;
    logic exp_y_c;
    logic mismatch_c;

    // Reference NAND evaluated on the vector currently being driven.
    assign exp_x_c    = ~&vec_q[7:4];
    assign exp_y_c    = ~&vec_q[3:0];
    assign mismatch_c = (x_i != exp_x_c) || (y_i != exp_y_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            dwell_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dwell_q     <= dwell_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    vec_d       = '0;
                    dwell_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end else begin
                    // Last edge of the dwell window: judge this vector, then advance.
                    dwell_d = '0;
                    if (mismatch_c) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                        if (!err_seen_q) begin
                            first_err_d = vec_q;
                            err_seen_d  = 1'b1;
                        end
                    end
`ifdef IC7420_DRV_STOP_ON_ERR_EN
                    if (mismatch_c || (vec_q == VEC_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
`else
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_cnt_d == '0);
    end

    assign vec_o         = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vec = first_err_q;

endmodule

// File: tb/tb_ic7420_pattern_driver.sv
// Directed self-checking bench for ic7420_pattern_driver (DWELL=4) with a
// behavioural NAND model that can be faulted (x stuck-at-1, x/y swapped).
`timescale 1ns/1ps
module tb_ic7420_pattern_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] vec_o;
    logic       x_i, y_i;
    logic       busy, done, pass;
    logic [8:0] err_cnt;
    logic [7:0] first_err_vec;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int mode     = 0;   // 0 golden, 1 x stuck-at-1, 2 x/y swapped

    always #5 clk = ~clk;

    assign x_i = (mode == 1) ? 1'b1 : (mode == 2) ? ~&vec_o[3:0] : ~&vec_o[7:4];
    assign y_i = (mode == 2) ? ~&vec_o[7:4] : ~&vec_o[3:0];

    ic7420_pattern_driver #(.DWELL(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec_o         (vec_o),
        .x_i           (x_i),
        .y_i           (y_i),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_vec (first_err_vec)
    );

    // Start a run and count busy cycles until done; reports the post-start state.
    task automatic run_once(output int bcyc, output bit tmo,
                            output logic b0, output logic [7:0] v0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        b0    = busy;
        v0    = vec_o;
        start = 1'b0;
        bcyc  = 0;
        tmo   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++; if (vec_o !== 8'h00) begin fail_cnt++; $display("FAIL reset_vec got %h want 00", vec_o); end
        cmp_cnt++; if ({busy, done, pass} !== 3'b000) begin fail_cnt++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
        cmp_cnt++; if (err_cnt !== 9'd0) begin fail_cnt++; $display("FAIL reset_err got %0d want 0", err_cnt); end
        cmp_cnt++; if (first_err_vec !== 8'h00) begin fail_cnt++; $display("FAIL reset_first got %h want 00", first_err_vec); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmp_cnt++; if ({busy, done} !== 2'b00) begin fail_cnt++; $display("FAIL idle_flags got %b want 00", {busy, done}); end
    endtask

    task automatic test_golden();
        int bc; bit tmo; logic b0; logic [7:0] v0;
        mode = 0;
        run_once(bc, tmo, b0, v0);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL golden_timeout got timeout want done"); end
        cmp_cnt++; if (b0 !== 1'b1 || v0 !== 8'h00) begin fail_cnt++; $display("FAIL golden_start got busy=%b vec=%h want busy=1 vec=00", b0, v0); end
        cmp_cnt++; if (bc !== 1024) begin fail_cnt++; $display("FAIL golden_busy got %0d want 1024", bc); end
        cmp_cnt++; if ({done, pass, busy} !== 3'b110) begin fail_cnt++; $display("FAIL golden_flags got %b want 110", {done, pass, busy}); end
        cmp_cnt++; if (err_cnt !== 9'd0) begin fail_cnt++; $display("FAIL golden_err got %0d want 0", err_cnt); end
        cmp_cnt++; if (first_err_vec !== 8'h00) begin fail_cnt++; $display("FAIL golden_first got %h want 00", first_err_vec); end
        cmp_cnt++; if (vec_o !== 8'hFF) begin fail_cnt++; $display("FAIL golden_vec got %h want FF", vec_o); end
        repeat (3) @(negedge clk);
        cmp_cnt++; if ({done, vec_o} !== {1'b1, 8'hFF}) begin fail_cnt++; $display("FAIL done_hold got %b/%h want 1/FF", done, vec_o); end
    endtask

    task automatic test_x_stuck();
        int bc; bit tmo; logic b0; logic [7:0] v0;
        mode = 1;
        run_once(bc, tmo, b0, v0);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL stuck_timeout got timeout want done"); end
`ifdef IC7420_DRV_STOP_ON_ERR_EN
        cmp_cnt++; if (bc !== 964) begin fail_cnt++; $display("FAIL stuck_busy got %0d want 964", bc); end
        cmp_cnt++; if (err_cnt !== 9'd1) begin fail_cnt++; $display("FAIL stuck_err got %0d want 1", err_cnt); end
        cmp_cnt++; if (vec_o !== 8'hF0) begin fail_cnt++; $display("FAIL stuck_vec got %h want F0", vec_o); end
`else
        cmp_cnt++; if (bc !== 1024) begin fail_cnt++; $display("FAIL stuck_busy got %0d want 1024", bc); end
        cmp_cnt++; if (err_cnt !== 9'd16) begin fail_cnt++; $display("FAIL stuck_err got %0d want 16", err_cnt); end
        cmp_cnt++; if (vec_o !== 8'hFF) begin fail_cnt++; $display("FAIL stuck_vec got %h want FF", vec_o); end
`endif
        cmp_cnt++; if (first_err_vec !== 8'hF0) begin fail_cnt++; $display("FAIL stuck_first got %h want F0", first_err_vec); end
        cmp_cnt++; if ({done, pass} !== 2'b10) begin fail_cnt++; $display("FAIL stuck_flags got %b want 10", {done, pass}); end
        mode = 0;
    endtask

    task automatic test_swap();
        int bc; bit tmo; logic b0; logic [7:0] v0;
        mode = 2;
        run_once(bc, tmo, b0, v0);
        cmp_cnt++; if (tmo) begin fail_cnt++; $display("FAIL swap_timeout got timeout want done"); end
`ifdef IC7420_DRV_STOP_ON_ERR_EN
        cmp_cnt++; if (err_cnt !== 9'd1) begin fail_cnt++; $display("FAIL swap_err got %0d want 1", err_cnt); end
`else
        cmp_cnt++; if (err_cnt !== 9'd30) begin fail_cnt++; $display("FAIL swap_err got %0d want 30", err_cnt); end
`endif
        cmp_cnt++; if (first_err_vec !== 8'h0F) begin fail_cnt++; $display("FAIL swap_first got %h want 0F", first_err_vec); end
        cmp_cnt++; if (pass !== 1'b0) begin fail_cnt++; $display("FAIL swap_pass got %b want 0", pass); end
        mode = 0;
    endtask

    task automatic test_rst_mid();
        int bc; bit tmo; logic b0; logic [7:0] v0; bit hit;
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (vec_o == 8'h40) begin hit = 1'b1; break; end
        end
        cmp_cnt++; if (!hit) begin fail_cnt++; $display("FAIL rst_reach got vec=%h want 40", vec_o); end
        rst = 1'b1;
        #1;
        cmp_cnt++; if ({vec_o, busy, done, pass} !== 11'd0) begin fail_cnt++; $display("FAIL rst_async got vec=%h b/d/p=%b%b%b want 00/000", vec_o, busy, done, pass); end
        cmp_cnt++; if ({err_cnt, first_err_vec} !== 17'd0) begin fail_cnt++; $display("FAIL rst_async_err got %0d/%h want 0/00", err_cnt, first_err_vec); end
        @(negedge clk);
        rst  = 1'b0;
        mode = 0;
        run_once(bc, tmo, b0, v0);
        cmp_cnt++; if (tmo || bc !== 1024) begin fail_cnt++; $display("FAIL rst_rerun_busy got %0d want 1024", bc); end
        cmp_cnt++; if ({pass, err_cnt} !== {1'b1, 9'd0}) begin fail_cnt++; $display("FAIL rst_rerun_pass got %b/%0d want 1/0", pass, err_cnt); end
    endtask

    task automatic test_start_ignored();
        int bc; bit tmo;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc  = 1;
        tmo = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (vec_o == 8'h10 && start == 1'b0 && i < 200) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
            if (busy) bc++;
            if (done) begin tmo = 1'b0; break; end
        end
        start = 1'b0;
        cmp_cnt++; if (tmo || bc !== 1024) begin fail_cnt++; $display("FAIL ignore_busy got %0d want 1024", bc); end
        cmp_cnt++; if (vec_o !== 8'hFF) begin fail_cnt++; $display("FAIL ignore_vec got %h want FF", vec_o); end
    endtask

    task automatic test_back_to_back();
        int bc; bit tmo;
        // Previous run left the block in DONE; holding start restarts with no gap.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cmp_cnt++; if ({busy, done, vec_o} !== {2'b10, 8'h00}) begin fail_cnt++; $display("FAIL b2b_restart got b/d=%b%b vec=%h want 10/00", busy, done, vec_o); end
        bc  = 0;
        tmo = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin tmo = 1'b0; break; end
        end
        cmp_cnt++; if (tmo || bc !== 1024) begin fail_cnt++; $display("FAIL b2b_busy got %0d want 1024", bc); end
        cmp_cnt++; if (pass !== 1'b1) begin fail_cnt++; $display("FAIL b2b_pass got %b want 1", pass); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_golden();
        test_x_stuck();
        test_swap();
        test_rst_mid();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
